// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter that runs two requesters' transfers over one APB bus,
// with a PREADY timeout so a hung slave cannot stall both requesters.
module apb_master_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
    logic          done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          elig0, elig1, pick1, tmo, finish;
    logic [31:0]   rd;

    // A requester whose done is showing this cycle is masked so a held valid is not re-granted.
    assign elig0  = req0_valid & ~done0_q;
    assign elig1  = req1_valid & ~done1_q;
    assign pick1  = elig1 & (~elig0 | ~last_q);
    assign tmo    = (TIMEOUT_CYC > 0) && state_q == ACCESS && !PREADY && cnt_q == CW'(TIMEOUT_CYC - 1);
    assign finish = state_q == ACCESS && (PREADY || tmo);
    assign rd     = (PREADY && !pwrite_q) ? PRDATA : '0;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (elig0 | elig1) ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = finish ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // last_q doubles as the owner of the transfer in flight.
    always_comb begin
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (state_q == IDLE && (elig0 | elig1)) begin
            last_d   = pick1;
            paddr_d  = pick1 ? req1_addr : req0_addr;
            pwrite_d = pick1 ? req1_write : req0_write;
            pwdata_d = pick1 ? req1_wdata : req0_wdata;
        end
        psel_d    = state_d != IDLE;
        penable_d = state_d == ACCESS;
        done0_d   = finish & ~last_q;
        done1_d   = finish & last_q;
        rdata0_d  = done0_d ? rd : '0;
        rdata1_d  = done1_d ? rd : '0;
        err0_d    = done0_d & tmo;
        err1_d    = done1_d & tmo;
        cnt_d     = (state_q == ACCESS && !PREADY) ? cnt_q + CW'(cnt_q != CMAX) : '0;
    end

    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign req0_done  = done0_q;
    assign req0_rdata = rdata0_q;
    assign req0_err   = err0_q;
    assign req1_done  = done1_q;
    assign req1_rdata = rdata1_q;
    assign req1_err   = err1_q;
endmodule
